// File: rtl/float_pkg.sv
// Shared constants and operand classification for the FP-to-integer path.
package float_pkg;

    localparam int unsigned BIAS   = 127;
    localparam int unsigned EXP_W  = 8;
    localparam int unsigned FRAC_W = 23;
    localparam int unsigned INT_W  = 32;
    localparam int unsigned SIG_W  = FRAC_W + 1;   // significand incl. hidden bit
    localparam int unsigned MAG_W  = INT_W - 1;    // unsigned magnitude width

    localparam logic [INT_W-1:0] INT_INDEFINITE = 32'h8000_0000;
    localparam logic [INT_W-1:0] INT_MAX        = 32'h7FFF_FFFF;
    localparam logic [INT_W-1:0] INT_MIN        = 32'h8000_0000;

    // Binary32 encoding of -2^31: the one overflowing exponent that still fits.
    localparam logic [INT_W-1:0] FLOAT_NEG_2_31 = 32'hCF00_0000;

    localparam logic [EXP_W-1:0] EXP_MAX = '1;

    typedef enum logic [2:0] {
        ZERO,
        SUBNORMAL,
        NORMAL,
        INF,
        NAN
    } fp_class_e;

    // Classify a binary32 operand from its exponent and fraction fields.
    function automatic fp_class_e classify(input logic [EXP_W-1:0]  exp_f,
                                           input logic [FRAC_W-1:0] frac_f);
        fp_class_e cls;
        if (exp_f == '0) begin
            cls = (frac_f == '0) ? ZERO : SUBNORMAL;
        end else if (exp_f == EXP_MAX) begin
            cls = (frac_f == '0) ? INF : NAN;
        end else begin
            cls = NORMAL;
        end
        return cls;
    endfunction

endpackage

// File: rtl/f2i_shift.sv
// Combinational align/shift unit: moves a 24-bit significand to integer
// alignment given the unbiased exponent, reporting discarded bits (sticky)
// and exponents too large for a 31-bit magnitude (overflow).
module f2i_shift
    import float_pkg::*;
(
    input  logic [SIG_W-1:0]  sig_i,
    input  logic signed [9:0] exp_i,
    output logic [MAG_W-1:0]  mag_o,
    output logic              sticky_o,
    output logic              overflow_o
);

    logic [4:0]       rshamt;
    logic [2:0]       lshamt;
    logic [SIG_W-1:0] lost_mask;

    // Select right shift, left shift, flush or overflow by exponent range.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        mag_o      = '0;
        sticky_o   = 1'b0;
        overflow_o = 1'b0;
        // Only meaningful for 0 <= e <= 23; modular arithmetic keeps it 5 bits.
        rshamt     = 5'd23 - exp_i[4:0];
        // e - 23 for 24 <= e <= 30; congruent to e + 1 modulo 8.
        lshamt     = exp_i[2:0] + 3'd1;
        lost_mask  = (24'd1 << rshamt) - 24'd1;

        if (exp_i < 10'sd0) begin
            // Magnitude below one: everything is fraction.
            sticky_o = |sig_i;
        end else if (exp_i <= 10'sd23) begin
            mag_o    = {7'b0, sig_i >> rshamt};
            sticky_o = |(sig_i & lost_mask);
        end else if (exp_i <= 10'sd30) begin
            mag_o = {7'b0, sig_i} << lshamt;
        end else begin
            overflow_o = 1'b1;
        end
    end

endmodule

// File: rtl/float_to_int.sv
// Registered binary32 -> signed int32 converter, truncating toward zero.
// Optional build macro FLOAT_TO_INT_SAT_EN: invalid inputs saturate
// (+Inf/+overflow -> INT_MAX, -Inf/-overflow -> INT_MIN, NaN -> 0)
// instead of returning the integer-indefinite value.
module float_to_int
    import float_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in_i,
    input  logic [INT_W-1:0] float_i,
    output logic             valid_out_o,
    output logic [INT_W-1:0] int_o,
    output logic             precision_lost_o,
    output logic             denormal_o,
    output logic             invalid_o
);

    logic              sign;
    logic [EXP_W-1:0]  exp_f;
    logic [FRAC_W-1:0] frac_f;
    fp_class_e         cls;
    logic signed [9:0] exp_unb;

    logic [MAG_W-1:0]  mag;
    logic              sticky;
    logic              overflow;

    logic [INT_W-1:0]  int_d,  int_q;
    logic              pl_d,   pl_q;
    logic              dn_d,   dn_q;
    logic              inv_d,  inv_q;
    logic              valid_q;

    assign sign    = float_i[31];
    assign exp_f   = float_i[30:23];
    assign frac_f  = float_i[22:0];
    assign cls     = classify(exp_f, frac_f);
    assign exp_unb = $signed({2'b00, exp_f}) - 10'sd127;

    f2i_shift u_shift (
        .sig_i      ({1'b1, frac_f}),
        .exp_i      (exp_unb),
        .mag_o      (mag),
        .sticky_o   (sticky),
        .overflow_o (overflow)
    );

    // Result returned for NaN, infinities and out-of-range magnitudes.
    function automatic logic [INT_W-1:0] invalid_result(input logic is_nan,
                                                        input logic neg);
`ifdef FLOAT_TO_INT_SAT_EN
        if (is_nan) begin
            return '0;
        end
        return neg ? INT_MIN : INT_MAX;
`else
        return (is_nan | neg | 1'b1) ? INT_INDEFINITE : INT_INDEFINITE;
`endif
    endfunction

    // Classify the operand, apply the sign and derive the status flags.
    always_comb begin
        int_d = '0;
        pl_d  = 1'b0;
        dn_d  = 1'b0;
        inv_d = 1'b0;

        unique case (cls)
            ZERO: begin
                int_d = '0;
            end
            SUBNORMAL: begin
                dn_d = 1'b1;
                pl_d = 1'b1;
            end
            INF: begin
                inv_d = 1'b1;
                int_d = invalid_result(1'b0, sign);
            end
            NAN: begin
                inv_d = 1'b1;
                int_d = invalid_result(1'b1, sign);
            end
            NORMAL: begin
                if (overflow) begin
                    if (float_i == FLOAT_NEG_2_31) begin
                        int_d = INT_MIN;
                    end else begin
                        inv_d = 1'b1;
                        int_d = invalid_result(1'b0, sign);
                    end
                end else begin
                    int_d = sign ? -{1'b0, mag} : {1'b0, mag};
                    pl_d  = sticky;
                end
            end
            default: begin
                int_d = '0;
            end
        endcase
    end

    // Output register: data follows float_i every cycle; valid follows the qualifier.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: control and data registers are all reset so outputs read zero during reset.
        if (rst) begin
            int_q   <= '0;
            pl_q    <= 1'b0;
            dn_q    <= 1'b0;
            inv_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            int_q   <= int_d;
            pl_q    <= pl_d;
            dn_q    <= dn_d;
            inv_q   <= inv_d;
            valid_q <= valid_in_i;
        end
    end

    assign int_o            = int_q;
    assign precision_lost_o = pl_q;
    assign denormal_o       = dn_q;
    assign invalid_o        = inv_q;
    assign valid_out_o      = valid_q;

endmodule

// File: tb/tb_float_to_int.sv
// Directed self-checking bench for float_to_int.
module tb_float_to_int;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in_i;
    logic [31:0] float_i;
    logic        valid_out_o;
    logic [31:0] int_o;
    logic        precision_lost_o;
    logic        denormal_o;
    logic        invalid_o;

    int n_vec = 0;
    int n_err = 0;

    float_to_int dut (
        .clk              (clk),
        .rst              (rst),
        .valid_in_i       (valid_in_i),
        .float_i          (float_i),
        .valid_out_o      (valid_out_o),
        .int_o            (int_o),
        .precision_lost_o (precision_lost_o),
        .denormal_o       (denormal_o),
        .invalid_o        (invalid_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Flags packed as {valid_out, precision_lost, denormal, invalid}.
    task automatic check_outputs(input string tag, input logic [31:0] exp_int, input logic [3:0] exp_flags);
        check({tag, ".int"}, int_o, exp_int);
        check({tag, ".flags"}, {28'b0, valid_out_o, precision_lost_o, denormal_o, invalid_o},
              {28'b0, exp_flags});
    endtask

    // Drive at a falling edge, capture on the next rising edge, check at the
    // following falling edge; consecutive calls therefore stream one per cycle.
    task automatic vec(input string tag, input logic [31:0] f, input logic v,
                       input logic [31:0] exp_int, input logic [3:0] exp_flags);
        float_i    = f;
        valid_in_i = v;
        @(negedge clk);
        check_outputs(tag, exp_int, exp_flags);
    endtask

`ifdef FLOAT_TO_INT_SAT_EN
    localparam logic [31:0] POS_INV = 32'h7FFF_FFFF;
    localparam logic [31:0] NAN_INV = 32'h0000_0000;
`else
    localparam logic [31:0] POS_INV = 32'h8000_0000;
    localparam logic [31:0] NAN_INV = 32'h8000_0000;
`endif

    initial begin
        rst        = 1'b1;
        valid_in_i = 1'b1;
        float_i    = 32'h40A0_0000;
        #12;
        check_outputs("reset", 32'h0, 4'b0000);
        @(negedge clk);
        check_outputs("reset_hold", 32'h0, 4'b0000);
        rst = 1'b0;

        // Integer-valued inputs
        vec("five",      32'h40A0_0000, 1'b1, 32'd5,          4'b1000);
        vec("d129",      32'h4301_0000, 1'b1, 32'd129,        4'b1000);
        vec("neg_five",  32'hC0A0_0000, 1'b1, 32'hFFFF_FFFB,  4'b1000);
        vec("one",       32'h3F80_0000, 1'b1, 32'd1,          4'b1000);
        vec("e24",       32'h4B80_0001, 1'b1, 32'h0100_0002,  4'b1000);
        vec("e30_pos",   32'h4EFF_FFFF, 1'b1, 32'h7FFF_FF80,  4'b1000);
        vec("e30_neg",   32'hCEFF_FFFF, 1'b1, 32'h8000_0080,  4'b1000);
        // Fractional inputs
        vec("frac103",   32'h42CF_224E, 1'b1, 32'd103,        4'b1100);
        vec("half",      32'h3F00_0000, 1'b1, 32'd0,          4'b1100);
        vec("neg_frac",  32'hBF7F_FFFF, 1'b1, 32'd0,          4'b1100);
        // Zero and subnormal
        vec("pos_zero",  32'h0000_0000, 1'b1, 32'd0,          4'b1000);
        vec("neg_zero",  32'h8000_0000, 1'b1, 32'd0,          4'b1000);
        vec("denorm",    32'h0000_0001, 1'b1, 32'd0,          4'b1110);
        vec("neg_denrm", 32'h807F_FFFF, 1'b1, 32'd0,          4'b1110);
        // Range boundaries
        vec("neg_2_31",  32'hCF00_0000, 1'b1, 32'h8000_0000,  4'b1000);
        vec("pos_2_31",  32'h4F00_0000, 1'b1, POS_INV,        4'b1001);
        vec("neg_ovf",   32'hCF00_0001, 1'b1, 32'h8000_0000,  4'b1001);
        vec("pos_inf",   32'h7F80_0000, 1'b1, POS_INV,        4'b1001);
        vec("neg_inf",   32'hFF80_0000, 1'b1, 32'h8000_0000,  4'b1001);
        vec("nan",       32'h7FC0_0000, 1'b1, NAN_INV,        4'b1001);
        // valid_in low: data still converts, valid_out stays low
        vec("no_valid",  32'h40A0_0000, 1'b0, 32'd5,          4'b0000);
        // Streaming with valid toggling to show per-operand ordering
        vec("strm0",     32'h4120_0000, 1'b1, 32'd10,         4'b1000);
        vec("strm1",     32'hC120_0000, 1'b0, 32'hFFFF_FFF6,  4'b0000);
        vec("strm2",     32'h4140_0000, 1'b1, 32'd12,         4'b1000);
        vec("strm3",     32'h3FC0_0000, 1'b1, 32'd1,          4'b1100);

        // Mid-stream reset: asynchronous clear, in-flight result dropped.
        float_i    = 32'h42CF_224E;
        valid_in_i = 1'b1;
        @(posedge clk);
        #1;
        check_outputs("pre_rst", 32'd103, 4'b1100);
        float_i = 32'h4301_0000;
        #2;
        rst = 1'b1;
        #1;
        check_outputs("async_rst", 32'h0, 4'b0000);
        @(negedge clk);
        @(negedge clk);
        check_outputs("rst_held", 32'h0, 4'b0000);
        rst = 1'b0;
        vec("post_rst_idle", 32'h40A0_0000, 1'b0, 32'd5,   4'b0000);
        vec("post_rst_vld",  32'h4301_0000, 1'b1, 32'd129, 4'b1000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
